// File: rtl/dct_pkg.sv
// ---------------------------------------------------------------------------
// dct_pkg
// Shared definitions for the 8x8 DCT front end: block geometry, the bank and
// read-FSM state encodings, and the JPEG level-shift constant.
// ---------------------------------------------------------------------------
package dct_pkg;

  localparam int BLK_N     = 8;
  localparam int BLK_WORDS = 64;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_st_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASM     = 2'd1,
    PRESENT = 2'd2
  } rd_st_e;

  // 128 << frac, masked to the word width. The caller truncates to DATA_W.
  function automatic logic [63:0] lvl_shift(input int frac, input int data_w);
    logic [63:0] mask;
    mask = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
    return (64'd128 << frac) & mask;
  endfunction

endpackage

// File: rtl/strip_bank_mem.sv
// ---------------------------------------------------------------------------
// strip_bank_mem
// One 8-line x IMG_W-word strip bank.
//   clk      : clock
//   wr_en    : write LANES words at (wr_line, wr_col .. wr_col+LANES-1)
//   wr_line  : line 0..7 being written
//   wr_col   : leftmost column of the write beat
//   wr_data  : LANES words, lane 0 in the LSBs is the leftmost pixel
//   rd_line  : line to read
//   rd_col   : leftmost column of the 8-word row read (block-aligned)
//   rd_row   : 8 words, word k = column rd_col+k, word 0 in the LSBs
// ---------------------------------------------------------------------------
module strip_bank_mem
  import dct_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 64,
  parameter int LANES  = 1,
  parameter int COL_W  = $clog2(IMG_W)
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [2:0]                wr_line,
  input  logic [COL_W-1:0]          wr_col,
  input  logic [LANES*DATA_W-1:0]   wr_data,
  input  logic [2:0]                rd_line,
  input  logic [COL_W-1:0]          rd_col,
  output logic [BLK_N*DATA_W-1:0]   rd_row
);

  logic [DATA_W-1:0] mem_q [BLK_N][IMG_W];

  // NOTE: the pixel array has no reset; every word is written before the
  // read side is allowed to look at it, so clearing it would only cost area.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        mem_q[wr_line][wr_col + COL_W'(l)] <= wr_data[l*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < BLK_N; k++) begin
      rd_row[k*DATA_W +: DATA_W] = mem_q[rd_line][rd_col + COL_W'(k)];
    end
  end

endmodule

// File: rtl/raster_to_block_buf.sv
// ---------------------------------------------------------------------------
// raster_to_block_buf
// Raster-to-8x8-block reorder buffer in front of the DCT core. Collects
// 8-line strips into two ping-pong banks and presents each 8x8 block as one
// 64-word vector, optionally level-shifted by (128 << FRAC).
//   clk, rst_n  : clock, synchronous active-low reset
//   in_valid    : input beat valid
//   in_data     : LANES pixels, lane 0 (LSBs) leftmost
//   in_ready    : a beat is accepted when in_valid && in_ready
//   out_valid   : out_block holds a complete block
//   out_block   : row-major block, word i at bits [i*DATA_W +: DATA_W]
//   out_ready   : downstream accepts the block
//   out_blk_col : horizontal block index of out_block within the strip
// ---------------------------------------------------------------------------
module raster_to_block_buf
  import dct_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int FRAC     = 8,
  parameter int IMG_W    = 64,
  parameter int LANES    = 1,
  parameter int SHIFT_EN = 0,
  localparam int BC_W    = (IMG_W / 8 > 1) ? $clog2(IMG_W / 8) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [LANES*DATA_W-1:0]     in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [BLK_WORDS*DATA_W-1:0] out_block,
  input  logic                        out_ready,
  output logic [BC_W-1:0]             out_blk_col
);

  localparam int                COL_W    = $clog2(IMG_W);
  localparam int                NBLK     = IMG_W / BLK_N;
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - LANES);
  localparam logic [BC_W-1:0]   LAST_BLK = BC_W'(NBLK - 1);
  localparam logic [DATA_W-1:0] SHIFT_C  =
    (SHIFT_EN != 0) ? DATA_W'(lvl_shift(FRAC, DATA_W)) : '0;

  bank_st_e                      bank_st_q [2];
  bank_st_e                      bank_st_d [2];
  logic [COL_W-1:0]              wr_col_q, wr_col_d;
  logic [2:0]                    wr_line_q, wr_line_d;
  logic                          wr_bank_q, wr_bank_d;
  rd_st_e                        rd_st_q, rd_st_d;
  logic                          rd_bank_q, rd_bank_d;
  logic [BC_W-1:0]               blk_col_q, blk_col_d;
  logic [2:0]                    row_q, row_d;
  logic                          out_valid_q, out_valid_d;
  logic [BLK_WORDS*DATA_W-1:0]   out_block_q, out_block_d;

  logic                          accept;
  logic [COL_W-1:0]              rd_col;
  logic [BLK_N*DATA_W-1:0]       rd_row_b0, rd_row_b1, rd_row;

  // in_ready depends only on registered bank state, never on out_ready.
  assign in_ready = (bank_st_q[wr_bank_q] == EMPTY) ||
                    (bank_st_q[wr_bank_q] == FILLING);
  assign accept   = in_valid && in_ready;
  assign rd_col   = COL_W'({blk_col_q, 3'b000});
  assign rd_row   = rd_bank_q ? rd_row_b1 : rd_row_b0;

  strip_bank_mem #(.DATA_W(DATA_W), .IMG_W(IMG_W), .LANES(LANES), .COL_W(COL_W)) u_bank0 (
    .clk     (clk),
    .wr_en   (accept && !wr_bank_q),
    .wr_line (wr_line_q),
    .wr_col  (wr_col_q),
    .wr_data (in_data),
    .rd_line (row_q),
    .rd_col  (rd_col),
    .rd_row  (rd_row_b0)
  );

  strip_bank_mem #(.DATA_W(DATA_W), .IMG_W(IMG_W), .LANES(LANES), .COL_W(COL_W)) u_bank1 (
    .clk     (clk),
    .wr_en   (accept && wr_bank_q),
    .wr_line (wr_line_q),
    .wr_col  (wr_col_q),
    .wr_data (in_data),
    .rd_line (row_q),
    .rd_col  (rd_col),
    .rd_row  (rd_row_b1)
  );

  // The write side only touches a bank that is EMPTY/FILLING and the read
  // side only one that is FULL/DRAINING, so both may update bank_st_d in the
  // same cycle without ever colliding on one bank.
  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a signal unassigned,
    // which would otherwise infer a latch.
    bank_st_d   = bank_st_q;
    wr_col_d    = wr_col_q;
    wr_line_d   = wr_line_q;
    wr_bank_d   = wr_bank_q;
    rd_st_d     = rd_st_q;
    rd_bank_d   = rd_bank_q;
    blk_col_d   = blk_col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_block_d = out_block_q;

    if (accept) begin
      if (bank_st_q[wr_bank_q] == EMPTY) bank_st_d[wr_bank_q] = FILLING;
      if (wr_col_q == LAST_COL) begin
        wr_col_d  = '0;
        wr_line_d = wr_line_q + 3'd1;
        if (wr_line_q == 3'd7) begin
          bank_st_d[wr_bank_q] = FULL;
          wr_bank_d            = ~wr_bank_q;
        end
      end else begin
        wr_col_d = wr_col_q + COL_W'(LANES);
      end
    end

    case (rd_st_q)
      IDLE: begin
        if (bank_st_q[rd_bank_q] == FULL) begin
          bank_st_d[rd_bank_q] = DRAINING;
          rd_st_d              = ASM;
          row_d                = '0;
        end
      end
      ASM: begin
        // One block row per cycle; the shift wraps at DATA_W bits.
        for (int k = 0; k < BLK_N; k++) begin
          out_block_d[(int'(row_q)*BLK_N + k)*DATA_W +: DATA_W] =
            rd_row[k*DATA_W +: DATA_W] - SHIFT_C;
        end
        if (row_q == 3'd7) begin
          rd_st_d     = PRESENT;
          out_valid_d = 1'b1;
        end else begin
          row_d = row_q + 3'd1;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (blk_col_q == LAST_BLK) begin
            bank_st_d[rd_bank_q] = EMPTY;
            rd_bank_d            = ~rd_bank_q;
            blk_col_d            = '0;
            rd_st_d              = IDLE;
          end else begin
            blk_col_d = blk_col_q + BC_W'(1);
            row_d     = '0;
            rd_st_d   = ASM;
          end
        end
      end
      default: rd_st_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_st_q[0] <= EMPTY;
      bank_st_q[1] <= EMPTY;
      wr_col_q     <= '0;
      wr_line_q    <= '0;
      wr_bank_q    <= 1'b0;
      rd_st_q      <= IDLE;
      rd_bank_q    <= 1'b0;
      blk_col_q    <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_block_q  <= '0;
    end else begin
      bank_st_q    <= bank_st_d;
      wr_col_q     <= wr_col_d;
      wr_line_q    <= wr_line_d;
      wr_bank_q    <= wr_bank_d;
      rd_st_q      <= rd_st_d;
      rd_bank_q    <= rd_bank_d;
      blk_col_q    <= blk_col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_block_q  <= out_block_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_block   = out_block_q;
  assign out_blk_col = blk_col_q;

endmodule
